// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle,
// {remainder, quotient} presented in divres with a one-cycle ready pulse.
module div_iter #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  sign,
    input  logic [DATA_W-1:0]     opr1,
    input  logic [DATA_W-1:0]     opr2,
    input  logic                  cancel,
    output logic                  busy,
    output logic                  ready,
    output logic [2*DATA_W-1:0]   divres
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_W-1:0]     rem_q, rem_d;
    logic [DATA_W-1:0]     quo_q, quo_d;
    logic [DATA_W-1:0]     dvs_q, dvs_d;
    logic                  qneg_q, qneg_d;
    logic                  rneg_q, rneg_d;
    logic [2*DATA_W-1:0]   divres_q, divres_d;

    logic [DATA_W-1:0]     a_abs, b_abs;
    logic [DATA_W:0]       shifted, diff;
    logic                  ge;
    logic [DATA_W-1:0]     rem_step, quo_step, rem_fix, quo_fix;

    // One restoring step on the DATA_W+1-bit partial remainder.
    always_comb begin
        a_abs    = (sign && opr1[DATA_W-1]) ? ('0 - opr1) : opr1;
        b_abs    = (sign && opr2[DATA_W-1]) ? ('0 - opr2) : opr2;
        shifted  = {rem_q, quo_q[DATA_W-1]};
        diff     = shifted - {1'b0, dvs_q};
        ge       = (shifted >= {1'b0, dvs_q});
        rem_step = ge ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
        quo_step = {quo_q[DATA_W-2:0], ge};
        rem_fix  = rneg_q ? ('0 - rem_step) : rem_step;
        quo_fix  = qneg_q ? ('0 - quo_step) : quo_step;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        divres_d = divres_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (opr2 != '0) begin
                        state_d = S_CALC;
                        cnt_d   = CNT_W'(DATA_W);
                        rem_d   = '0;
                        quo_d   = a_abs;
                        dvs_d   = b_abs;
                        qneg_d  = sign && (opr1[DATA_W-1] != opr2[DATA_W-1]);
                        rneg_d  = sign && opr1[DATA_W-1];
                    end else begin
                        state_d  = S_DONE;
                        divres_d = {opr1, {DATA_W{1'b1}}};
                    end
                end
            end
            S_CALC: begin
                rem_d = rem_step;
                quo_d = quo_step;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d  = S_DONE;
                    divres_d = {rem_fix, quo_fix};
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // A flush kills whatever was in flight, including a same-cycle start.
        if (cancel) begin
            state_d  = S_IDLE;
            divres_d = divres_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            divres_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            divres_q <= divres_d;
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign ready  = (state_q == S_DONE);
    assign divres = divres_q;

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: directed vector table, multi-cycle corner
// sequences, and random operations checked against an arithmetic reference.
module tb_div_iter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        sign = 1'b0;
    logic [31:0] opr1 = '0;
    logic [31:0] opr2 = '0;
    logic        cancel = 1'b0;
    logic        busy, ready;
    logic [63:0] divres;

    int n_checks = 0;
    int n_pass   = 0;

    div_iter #(.DATA_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .sign(sign),
        .opr1(opr1), .opr2(opr2), .cancel(cancel),
        .busy(busy), .ready(ready), .divres(divres)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference: plain integer division; signed uses 64-bit truncating arithmetic.
    function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (!s) return {a % b, a / b};
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        q  = sa / sb;
        r  = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Start in cycle 0, wait for ready; toggles operands and start while busy.
    task automatic do_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                         output logic [63:0] res, output int lat);
        @(negedge clk);
        start = 1'b1; sign = s; opr1 = a; opr2 = b;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!ready && lat < 100) begin
            opr1  = $urandom;
            opr2  = $urandom;
            sign  = 1'($urandom_range(0, 1));
            start = 1'($urandom_range(0, 1));
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        res = divres;
    endtask

    initial begin
        logic [63:0] res, prev;
        int          lat, nready, rcyc;
        logic        s;
        logic [31:0] a, b;

        vecs[0] = '{1'b0, 32'd100,        32'd7,        {32'h0000_0002, 32'h0000_000E}, 33};
        vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,        {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33};
        vecs[2] = '{1'b1, 32'd7,          32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}, 33};
        vecs[3] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000}, 33};
        vecs[4] = '{1'b0, 32'hFFFF_FFFF,  32'd1,        {32'h0000_0000, 32'hFFFF_FFFF}, 33};
        vecs[5] = '{1'b0, 32'd5,          32'd0,        {32'h0000_0005, 32'hFFFF_FFFF}, 1};
        vecs[6] = '{1'b1, 32'd5,          32'd0,        {32'h0000_0005, 32'hFFFF_FFFF}, 1};
        vecs[7] = '{1'b1, 32'hFFFF_FFF9,  32'd0,        {32'hFFFF_FFF9, 32'hFFFF_FFFF}, 1};

        // Reset state
        #2;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_ready", 64'(ready), 64'd0);
        check("reset_divres", divres, 64'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;

        // Directed table
        foreach (vecs[i]) begin
            do_op(vecs[i].s, vecs[i].a, vecs[i].b, res, lat);
            $display("vec %0d: s=%0d %h/%h -> %h lat %0d", i, vecs[i].s, vecs[i].a, vecs[i].b, res, lat);
            check($sformatf("vec%0d_res", i), res, vecs[i].exp);
            check($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
            @(negedge clk);
            check($sformatf("vec%0d_busy_after", i), 64'(busy), 64'd0);
            check($sformatf("vec%0d_ready_pulse", i), 64'(ready), 64'd0);
            check($sformatf("vec%0d_divres_held", i), divres, vecs[i].exp);
        end

        // Cancel mid-CALC, then a second operation
        prev = divres;
        @(negedge clk);
        start = 1'b1; sign = 1'b0; opr1 = 32'd100; opr2 = 32'd7;
        nready = 0; rcyc = -1;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            start  = 1'b0;
            cancel = 1'b0;
            if (ready) begin nready++; rcyc = k; end
            if (k == 10) cancel = 1'b1;
            if (k == 11) check("cancel_divres_kept", divres, prev);
            if (k == 11) check("cancel_busy_low", 64'(busy), 64'd0);
            if (k == 12) begin start = 1'b1; sign = 1'b0; opr1 = 32'd9; opr2 = 32'd3; end
            if (k >= 13 && k <= 43) begin
                start = 1'($urandom_range(0, 1));
                opr1 = $urandom; opr2 = $urandom; sign = 1'($urandom_range(0, 1));
            end
        end
        $display("cancel seq: readies %0d at cycle %0d divres %h", nready, rcyc, divres);
        check("cancel_ready_count", 64'(nready), 64'd1);
        check("cancel_ready_cycle", 64'(rcyc), 64'd45);
        check("cancel_divres", divres, {32'd0, 32'd3});

        // Cancel in DONE cycle: ready still shown, result kept
        @(negedge clk);
        start = 1'b1; sign = 1'b0; opr1 = 32'd5; opr2 = 32'd0;
        @(negedge clk);
        start = 1'b0;
        cancel = 1'b1;
        check("done_cancel_ready", 64'(ready), 64'd1);
        @(negedge clk);
        cancel = 1'b0;
        $display("cancel in DONE: busy %0d divres %h", busy, divres);
        check("done_cancel_idle", 64'(busy), 64'd0);
        check("done_cancel_divres", divres, {32'd5, 32'hFFFF_FFFF});

        // Start together with cancel in IDLE is dropped
        start = 1'b1; cancel = 1'b1; opr1 = 32'd8; opr2 = 32'd2;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        $display("start+cancel: busy %0d", busy);
        check("start_cancel_dropped", 64'(busy), 64'd0);

        // Asynchronous reset mid-CALC
        @(negedge clk);
        start = 1'b1; sign = 1'b0; opr1 = 32'd100; opr2 = 32'd7;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("pre_reset_busy", 64'(busy), 64'd1);
        rst = 1'b0;
        #1;
        $display("async reset: busy %0d ready %0d divres %h", busy, ready, divres);
        check("async_busy", 64'(busy), 64'd0);
        check("async_ready", 64'(ready), 64'd0);
        check("async_divres", divres, 64'd0);
        #2 rst = 1'b1;
        do_op(1'b0, 32'd100, 32'd7, res, lat);
        $display("after reset: %h lat %0d", res, lat);
        check("post_reset_res", res, {32'd2, 32'd14});
        check("post_reset_lat", 64'(lat), 64'd33);

        // Random back-to-back operations against the reference
        for (int i = 0; i < 40; i++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'($urandom_range(0, 3));
                1:       b = 32'($urandom_range(1, 255));
                2:       b = $urandom >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            do_op(s, a, b, res, lat);
            $display("rand %0d: s=%0d %h/%h -> %h lat %0d", i, s, a, b, res, lat);
            check($sformatf("rand%0d_res", i), res, ref_div(s, a, b));
            check($sformatf("rand%0d_lat", i), 64'(lat), (b == 0) ? 64'd1 : 64'd33);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
